key_event_gen: RTL
==================

Name: key_event_gen

Overview:
- Converts one debounced, clock-synchronous key level into single-cycle event pulses: press, release, long-press and auto-repeat.
- Sits directly downstream of a debounce stage (its sync_out drives key_in) and upstream of application logic such as an LED rotator or menu controller.
- Replaces ad-hoc rising-edge detection at top level with uniform, deterministic timing.

Parameters:
- CLOCK_HZ, 12_000_000, system clock frequency. CYCLES_PER_MS = CLOCK_HZ/1000, truncated; must be ≥1.
- LONG_PRESS_MS, 500, hold time before long_press fires; ≥1.
- REPEAT_MS, 100, repeat period after long_press; ≥1.
- REPEAT_ENABLE, 1, 1 = emit repeat pulses while long-held; 0 = none.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- key_in  input  1  debounced key level, already synchronous to clock, 1 = pressed.
- press  output  1  one-cycle pulse on key press.
- release  output  1  one-cycle pulse on key release.
- long_press  output  1  one-cycle pulse once per hold, at LONG_PRESS_MS.
- repeat  output  1  one-cycle pulse every REPEAT_MS while long-held.
- held  output  1  level: high while FSM is not IDLE.

Behaviour:
- Decided: one clock; reset is synchronous and active-high; ports named clock and reset.
- All outputs are registered. Reset value of every output, key_prev, counters and FSM is 0 / IDLE.
- Edge detect:
  - key_prev <= key_in each cycle.
  - rise = key_in & !key_prev; fall = !key_in & key_prev.
- ms tick: prescaler counts 0..CYCLES_PER_MS-1 and emits tick when it wraps. It restarts from 0 on rise, so timing is deterministic relative to press.
- FSM states IDLE, PRESSED, LONG_HELD:
  - IDLE: on rise, press=1 next cycle (latency 1 from the first sampled high); ms_cnt <= 0; go to PRESSED.
  - PRESSED:
    - On fall: release=1, go to IDLE.
    - Else on tick: ms_cnt++.
    - When a tick makes ms_cnt reach LONG_PRESS_MS: long_press=1, rep_cnt <= 0, go to LONG_HELD.
    - Net timing: long_press asserts exactly LONG_PRESS_MS*CYCLES_PER_MS cycles after press.
  - LONG_HELD:
    - On fall: release=1, go to IDLE.
    - Else on tick: rep_cnt++. When it reaches REPEAT_MS: repeat=REPEAT_ENABLE, rep_cnt <= 0.
    - Net timing: repeat period is REPEAT_MS*CYCLES_PER_MS cycles.
- Priority: fall beats a coincident long_press or repeat. Only release fires; the timed event is dropped.
- Never more than one of press/release/long_press/repeat high in the same cycle.
- held = (state != IDLE), registered, rising in the same cycle as press.
- One-cycle key_in pulse: press at N+1, release at N+2, held high for exactly 1 cycle.
- Counters:
  - ms_cnt width $clog2(LONG_PRESS_MS+1); rep_cnt width $clog2(REPEAT_MS+1).
  - Neither wraps: ms_cnt freezes once state leaves PRESSED.
  - Indefinite holds keep repeating with no overflow.
- Reset mid-operation: all outputs drop to 0 on the cycle after reset is sampled; no release pulse is emitted.
  - key_prev resets to 0, so a key still held after reset deasserts yields a fresh press one cycle after the first non-reset edge.
- key_in is not re-debounced or synchronized here; the upstream stage owns both.

Decomposition:
- Package key_event_pkg:
  - state_t enum {IDLE, PRESSED, LONG_HELD}.
  - Function cycles_per_ms(CLOCK_HZ).
  - Elaboration-time parameter checks (CYCLES_PER_MS≥1, LONG_PRESS_MS≥1, REPEAT_MS≥1), reported via $error.
- Sub-module ms_tick_gen: parameter CYCLES_PER_MS; ports clock, reset, restart, tick. Reused by the bounce-measurement logic.

Test Plan:
All cases use CLOCK_HZ=10_000 (10 cycles/ms), LONG_PRESS_MS=5, REPEAT_MS=2 unless noted.
1. Short press: key_in high for 20 cycles from edge T -> press at T+1, release 1 cycle after the falling sample, no long_press, held high for 20 cycles.
2. Long hold: key_in high for 120 cycles -> press at T+1, long_press at T+51, repeat at T+71, T+91, T+111, then release. Each pulse exactly 1 cycle wide.
3. Coincidence: key_in falls so that fall is sampled on the same edge that would fire long_press (the cycle that would yield long_press at T+51) -> release only at that cycle, long_press never asserted.
4. REPEAT_ENABLE=0, 120-cycle hold -> single long_press at T+51, zero repeat pulses, release at end.
5. Reset asserted 1 cycle at T+30 of a hold, key still high -> all outputs 0 and no release at T+31; press at T+32; long_press 50 cycles after that press.
6. Single-cycle key_in pulse, then 10 idle cycles, then another -> two press/release pairs each separated by 1 cycle; held never exceeds 1 cycle.

Source files
------------

// File: rtl/key_event_gen_pkg.sv
// ============================================================================
// Module   : key_event_pkg
// Purpose  : Shared state encoding and timing helpers for key_event_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  // Truncating division; a clock below 1 kHz yields 0 and is rejected at elaboration.
  function automatic int unsigned cycles_per_ms(input int unsigned clock_hz);
    return clock_hz / 1000;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_event_gen_if.sv
// ============================================================================
// Module   : key_event_if
// Purpose  : Key level in, event pulses and held level out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_event_if;
  logic key_in;
  logic press;
  logic release_pulse;
  logic long_press;
  logic repeat_pulse;
  logic held;

  modport master (
    output key_in,
    input  press,
    input  release_pulse,
    input  long_press,
    input  repeat_pulse,
    input  held
  );

  modport slave (
    input  key_in,
    output press,
    output release_pulse,
    output long_press,
    output repeat_pulse,
    output held
  );
endinterface

`default_nettype wire

// File: rtl/key_event_gen_ms_tick_gen.sv
// ============================================================================
// Module   : ms_tick_gen
// Purpose  : Millisecond prescaler; tick is high on the last count before wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_tick_gen #(
  parameter int unsigned CYCLES_PER_MS = 12_000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned     c_CW   = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(CYCLES_PER_MS - 1);

  logic [c_CW-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      r_cnt <= '0;
    end else if (r_cnt == c_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/key_event_gen.sv
// ============================================================================
// Module   : key_event_gen
// Purpose  : Turns a debounced key level into press/release/long/repeat pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event_gen
  import key_event_pkg::*;
#(
  parameter int unsigned CLOCK_HZ      = 12_000_000,
  parameter int unsigned LONG_PRESS_MS = 500,
  parameter int unsigned REPEAT_MS     = 100,
  parameter bit          REPEAT_ENABLE = 1'b1
) (
  input  logic           clock,
  input  logic           reset,
  key_event_if.slave     bus
);

  localparam int unsigned c_CPM   = cycles_per_ms(CLOCK_HZ);
  localparam int unsigned c_MS_W  = $clog2(LONG_PRESS_MS + 1);
  localparam int unsigned c_REP_W = $clog2(REPEAT_MS + 1);

  localparam logic [c_MS_W-1:0]  c_MS_LAST  = c_MS_W'(LONG_PRESS_MS - 1);
  localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_MS - 1);

  localparam logic [1:0] c_ST_IDLE      = IDLE;
  localparam logic [1:0] c_ST_PRESSED   = PRESSED;
  localparam logic [1:0] c_ST_LONG_HELD = LONG_HELD;

  generate
    if (c_CPM < 1) begin : g_chk_cpm
      $error("key_event_gen: CLOCK_HZ must give at least one cycle per ms");
    end
    if (LONG_PRESS_MS < 1) begin : g_chk_long
      $error("key_event_gen: LONG_PRESS_MS must be at least 1");
    end
    if (REPEAT_MS < 1) begin : g_chk_rep
      $error("key_event_gen: REPEAT_MS must be at least 1");
    end
  endgenerate

  logic                r_key_prev;
  logic [1:0]          r_state;
  logic [c_MS_W-1:0]   r_ms_cnt;
  logic [c_REP_W-1:0]  r_rep_cnt;
  logic                r_press;
  logic                r_release;
  logic                r_long;
  logic                r_repeat;
  logic                r_held;

  logic w_rise;
  logic w_fall;
  logic w_tick;

  assign w_rise = bus.key_in & ~r_key_prev;
  assign w_fall = ~bus.key_in & r_key_prev;

  // Restarting on rise aligns every ms boundary to the press edge.
  ms_tick_gen #(
    .CYCLES_PER_MS (c_CPM)
  ) u_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (w_rise),
    .tick    (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_key_prev <= 1'b0;
      r_state    <= c_ST_IDLE;
      r_ms_cnt   <= '0;
      r_rep_cnt  <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_key_prev <= bus.key_in;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;

      case (r_state)
        c_ST_IDLE: begin
          if (w_rise) begin
            r_press  <= 1'b1;
            r_held   <= 1'b1;
            r_ms_cnt <= '0;
            r_state  <= c_ST_PRESSED;
          end
        end

        // Fall is tested first so a coincident timed event is dropped.
        c_ST_PRESSED: begin
          if (w_fall) begin
            r_release <= 1'b1;
            r_held    <= 1'b0;
            r_state   <= c_ST_IDLE;
          end else if (w_tick) begin
            r_ms_cnt <= r_ms_cnt + 1'b1;
            if (r_ms_cnt == c_MS_LAST) begin
              r_long    <= 1'b1;
              r_rep_cnt <= '0;
              r_state   <= c_ST_LONG_HELD;
            end
          end
        end

        c_ST_LONG_HELD: begin
          if (w_fall) begin
            r_release <= 1'b1;
            r_held    <= 1'b0;
            r_state   <= c_ST_IDLE;
          end else if (w_tick) begin
            if (r_rep_cnt == c_REP_LAST) begin
              r_repeat  <= REPEAT_ENABLE;
              r_rep_cnt <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_held  <= 1'b0;
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign bus.press         = r_press;
  assign bus.release_pulse = r_release;
  assign bus.long_press    = r_long;
  assign bus.repeat_pulse  = r_repeat;
  assign bus.held          = r_held;

endmodule

`default_nettype wire
